// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch stage: IDLE -> REQ (wait for ack) -> VALID (wait for consume).
// Fetch latency is 1+ cycles; upstream stalls hold address, and downstream backpressure holds instr/pc.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] imm16,
    input  logic [31:0] sext_imm,
    input  logic        branch_taken,
    input  logic        jump_en,
    input  logic [25:0] jump_index,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        VALID
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] branch_target;
    logic [31:0] next_pc;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};

    // Jump outranks branch when both resolve on the same consume edge.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_en) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC_ALIGNED;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign instr_valid = (state_q == VALID);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign imm16       = instr_q[15:0];

endmodule
